// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// No logic; state encoding and memory geometry only.
// Imported by imem_loader and imem_byte_packer.
package imem_loader_pkg;

    localparam int IMEM_DEPTH     = 71;
    localparam int IMEM_ADDR_W    = 7;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four stream bytes into one 32-bit word, first byte in the MSBs.
// Latency: word_o reflects a shifted byte the cycle after shift_i; word_full_o is combinational.
// Backpressure: none of its own; the caller only shifts on an accepted transfer.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // Shift register and byte counter; the counter wraps to 0 after the 4th byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 32'd0;
            cnt_q  <= 2'd0;
        end else if (clear_i) begin
            word_q <= 32'd0;
            cnt_q  <= 2'd0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign word_o      = word_q;
    // High while the byte completing the current word is being shifted in.
    assign word_full_o = shift_i & (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream (count header, then MSB-first words) and holds the CPU meanwhile.
// Latency: wr_en asserts the cycle after the 4th byte of a word is accepted; one WRITE cycle per word.
// Backpressure: in_ready only in HDR/DATA/CHK; in_valid low stalls forever. Optional IMEM_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        n_q, n_d;
    logic [31:0]       wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        xfer;
    logic        last_word;
    logic        pk_shift;
    logic        pk_clear;
    logic [31:0] pk_word;
    logic        pk_full;

    imem_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_i     (pk_shift),
        .clear_i     (pk_clear),
        .byte_i      (in_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    assign in_ready  = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign xfer      = in_valid & in_ready;
    assign last_word = (idx_q == ADDR_W'(n_q - 8'd1));

    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = idx_q;
    // The packer holds the complete word during WRITE; afterwards the captured copy is shown.
    assign wr_data  = (state_q == WRITE) ? pk_word : wr_data_q;
    // ERR keeps the CPU held so a partial image never runs.
    assign cpu_hold = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);

    // State, word index, header count and last-written-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= 8'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of header and data bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state logic: header check, byte collection, one-cycle write, optional checksum.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        wr_data_d = wr_data_q;
        pk_shift  = 1'b0;
        pk_clear  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = HDR;
                    idx_d    = '0;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = 8'd0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if ((in_data == 8'd0) || (in_data > DEPTH_B)) begin
                        state_d = ERR;
                    end else begin
                        n_d     = in_data;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    pk_shift = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ in_data;
`endif
                    if (pk_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_data_d = pk_word;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = DATA;
                end
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
`else
                state_d = ERR;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes plus scenario tasks.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [38:0] exp_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  tb_csum = 8'd0;
    int          xfer_cnt = 0;
    logic        last_xfer = 1'b0;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        last_xfer <= in_valid && in_ready;
        if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // Write monitor: every wr_en must match the scoreboard head and follow a transfer directly.
    always @(negedge clk) begin : mon
        logic [38:0] e;
        if (rst_n && wr_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_bad++;
                    $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             wr_addr, wr_data, e[38:32], e[31:0]);
                end
            end
            n_cmp++;
            if (last_xfer !== 1'b1) begin
                n_bad++;
                $display("FAIL write_latency: got prev-cycle transfer=%b, expected 1", last_xfer);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL ready_during_write: got in_ready=%b, expected 0", in_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start;
        @(negedge clk);
        start   = 1'b1;
        tb_csum = 8'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        if (gap > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap)) @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted within 100 cycles", b);
            in_valid = 1'b0;
        end else begin
            tb_csum ^= b;
            @(posedge clk);
        end
    endtask

    task automatic drop_valid;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [6:0] addr, input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
        exp_q.push_back({addr, w});
    endtask

    task automatic do_load(input logic [7:0] hdr, input int gap, input bit tail);
        pulse_start();
        send_byte(hdr, gap);
        for (int i = 0; i < words_q.size(); i++) send_word(7'(i), words_q[i], gap);
        if (tail) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(tb_csum, gap);
`endif
            drop_valid();
        end
    endtask

    task automatic wait_end(input string name, input logic e_done, input logic e_err, input logic e_hold);
        int k;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if ({done, err, cpu_hold, in_ready} !== {e_done, e_err, e_hold, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_end: got done=%b err=%b hold=%b ready=%b, expected done=%b err=%b hold=%b ready=0",
                     name, done, err, cpu_hold, in_ready, e_done, e_err, e_hold);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_writes: %0d expected writes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #4;
        n_cmp++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b wr_en=%b addr=%0d data=%h hold=%b done=%b err=%b, expected all 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, cpu_hold, done, err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_outputs: got ready=%b hold=%b done=%b err=%b, expected 0000",
                     in_ready, cpu_hold, done, err);
        end
    endtask

    task automatic test_nominal;
        words_q = '{32'h12345678, 32'h9ABCDEF0};
        pulse_start();
        n_cmp++;
        if ({cpu_hold, in_ready, done} !== 3'b110) begin
            n_bad++;
            $display("FAIL hdr_outputs: got hold=%b ready=%b done=%b, expected 1 1 0", cpu_hold, in_ready, done);
        end
        send_byte(8'h02, 0);
        for (int i = 0; i < words_q.size(); i++) send_word(7'(i), words_q[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, 0);
`endif
        drop_valid();
        wait_end("nominal", 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({wr_addr, wr_data, wr_en} !== {7'd1, 32'h9ABCDEF0, 1'b0}) begin
            n_bad++;
            $display("FAIL nominal_hold: got addr=%0d data=%h wr_en=%b, expected addr=1 data=9abcdef0 wr_en=0",
                     wr_addr, wr_data, wr_en);
        end
    endtask

    task automatic test_bad_header;
        words_q.delete();
        pulse_start();
        send_byte(8'h00, 0);
        drop_valid();
        wait_end("hdr_zero", 1'b0, 1'b1, 1'b1);
        pulse_start();
        send_byte(8'h48, 0);
        drop_valid();
        wait_end("hdr_72", 1'b0, 1'b1, 1'b1);
        words_q = '{32'hCAFEF00D};
        do_load(8'h01, 0, 1'b1);
        wait_end("recover", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gaps;
        int cnt0;
        words_q = '{32'hAABBCCDD};
        do_load(8'h01, 3, 1'b0);
        @(negedge clk);
        cnt0 = xfer_cnt;
        in_valid = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_data = tb_csum;
`else
        in_data = 8'h55;
`endif
        n_cmp++;
        if (wr_en !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_write_cycle: got wr_en=%b ready=%b, expected 1 0", wr_en, in_ready);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer_cnt !== cnt0 + 1) begin
`else
        if (xfer_cnt !== cnt0) begin
`endif
            n_bad++;
            $display("FAIL gap_consumed: got %0d transfers after WRITE, base %0d", xfer_cnt, cnt0);
        end
        in_valid = 1'b0;
        wait_end("gaps", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_depth;
        words_q.delete();
        for (int i = 0; i < 71; i++) words_q.push_back($urandom);
        do_load(8'h47, 0, 1'b1);
        wait_end("full", 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_addr !== 7'd70) begin
            n_bad++;
            $display("FAIL full_last_addr: got %0d, expected 70", wr_addr);
        end
    endtask

    task automatic test_reset_midload;
        words_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_word(7'd0, 32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 45'd0) begin
            n_bad++;
            $display("FAIL midload_reset: got ready=%b wr_en=%b addr=%0d data=%h hold=%b done=%b err=%b, expected all 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL midload_first_word: %0d writes missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        words_q = '{32'h0BADC0DE};
        do_load(8'h01, 0, 1'b1);
        wait_end("reload", 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_addr !== 7'd0) begin
            n_bad++;
            $display("FAIL reload_addr: got %0d, expected 0", wr_addr);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start();
        send_byte(8'h01, 0);
        send_word(7'd0, 32'h01020304, 0);
        send_byte(8'h05, 0);
        drop_valid();
        wait_end("csum_good", 1'b1, 1'b0, 1'b0);
        pulse_start();
        send_byte(8'h01, 0);
        send_word(7'd0, 32'h01020304, 0);
        send_byte(8'h06, 0);
        drop_valid();
        wait_end("csum_bad", 1'b0, 1'b1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_bad_header();
        test_gaps();
        test_full_depth();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The fetch stage reads words by PC; this block fills the same 71x32 array from a byte stream, e.g. a UART receiver or debug port.
- Holds the processor (cpu_hold) while loading, then releases it to fetch from address 0.
- Sits between the byte source and the instruction memory write port, replacing the file preload for in-system programming.

Parameters:
- DEPTH, 71, number of 32-bit instruction words in memory.
- ADDR_W, 7, write address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session from IDLE, DONE or ERR.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle (transfer = in_valid & in_ready).
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address being written.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  stall/hold request to the fetch stage.
- done  out  1  load completed successfully (level).
- err  out  1  load aborted on bad header or checksum (level).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0; word and byte counters cleared. Reset mid-load abandons the load; words already written stay in memory.
- States: IDLE, HDR, DATA, WRITE, CHK (optional feature only), DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to HDR.
  - cpu_hold=1; done=0; err=0; wr_addr=0; byte count=0.
- start in HDR/DATA/WRITE/CHK is ignored.
- HDR:
  - in_ready=1.
  - On transfer, the byte is N, the number of words.
  - If N==0 or N>DEPTH, go to ERR.
  - Otherwise store N and go to DATA.
- DATA:
  - in_ready=1.
  - Bytes arrive MSB first; word = {b0,b1,b2,b3}, matching binary listing order.
  - On the 4th transfer, go to WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0; wr_en=1, wr_addr=current index, wr_data=assembled word.
  - Next cycle:
    - If index==N-1, go to DONE (or CHK when the feature is enabled).
    - Else index+1 and return to DATA.
- Latency: wr_en asserts the cycle after the 4th byte transfer.
- wr_addr never exceeds N-1 and never wraps.
- in_valid low stalls any state indefinitely with no timeout.
- A byte presented during WRITE is not consumed; the source holds it.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - The fetch stage restarts at PC 0. The PC reset itself is owned by fetch; loader release is its trigger.
- ERR:
  - err=1, cpu_hold stays 1 so the processor does not run a partial image, in_ready=0.
  - Leaves only on start or reset.
- wr_data holds the last written word between writes.
- wr_en is 0 in every state except WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - The loader keeps an 8-bit running XOR of the header and all data bytes.
  - After the last WRITE it enters CHK, with in_ready=1, and accepts one checksum byte.
  - If the checksum byte equals the running XOR, go to DONE; otherwise go to ERR.
  - The checksum resets to 0 on start.
- Without the macro: no CHK state and no XOR register; the last WRITE goes straight to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum loader_state_t: IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
  - localparams IMEM_DEPTH=71, IMEM_ADDR_W=7, BYTES_PER_WORD=4.
- One sub-module, imem_byte_packer:
  - 32-bit shift register plus 2-bit byte counter.
  - Inputs: shift strobe, clear.
  - Outputs: word and word_full.
- The top level keeps the FSM, index counter, header register and checksum.

Test Plan:
- Nominal load: start; bytes 0x02, 0x12,0x34,0x56,0x78, 0x9A,0xBC,0xDE,0xF0 with in_valid held high -> wr_en at addr 0 data 0x12345678, wr_en at addr 1 data 0x9ABCDEF0. Each wr_en is 1 cycle after the 4th byte. Then done=1, cpu_hold=0, in_ready=0.
- Bad header: start; header 0x00 -> err=1, cpu_hold=1, no wr_en. Repeat with header 0x48 (72 > DEPTH) -> err=1. Then start with header 0x01 plus 4 bytes -> err=0, done=1.
- Backpressure/gaps: header 0x01, random in_valid gaps, and a byte offered during WRITE -> that byte is not consumed. Single write of 0xAABBCCDD at addr 0.
- Full depth: header 0x47 (71), 284 bytes -> 71 writes at addrs 0..70 in order. Last wr_addr=70, no wrap, done=1.
- Reset mid-load: rst_n=0 after 6 data bytes -> all outputs 0 immediately (async). State is IDLE, and a new start reloads from addr 0.
- With IMEM_LOADER_CHECKSUM_EN: header 0x01, bytes 0x01,0x02,0x03,0x04.
  - Checksum byte 0x05 (0x01^0x01^0x02^0x03^0x04) -> done=1.
  - Checksum byte 0x06 -> err=1, cpu_hold=1.
